// File: rtl/mem_interface.sv
// ============================================================================
// Module   : mem_interface
// Purpose  : Four-state handshake bridge between CPU MAR/MDR control and a
//            single-port word RAM. Optional WAIT abort: MEM_IF_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_interface #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [31:0]       MARout,
    input  logic [31:0]       MDRout,
    output logic [31:0]       Mdatain,
    output logic              mem_done,
    output logic              mem_busy,
    output logic              addr_err,
    output logic              timeout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [31:0]         r_mdat;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_is_read;
    logic                r_re;
    logic                r_we;
    logic                r_done;
    logic                r_aerr;
    logic                w_req;
    logic                w_addr_bad;

    assign w_req      = Read | Write;
    assign w_addr_bad = |MARout[31:ADDR_W];

`ifdef MEM_IF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_tmo;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state   <= S_IDLE;
            r_mdat    <= 32'd0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_is_read <= 1'b0;
            r_re      <= 1'b0;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
            r_aerr    <= 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
            r_cnt     <= '0;
            r_tmo     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr    <= MARout[ADDR_W-1:0];
                        r_wdata   <= MDRout;
                        r_is_read <= Read;
                        // Out-of-range address skips the RAM entirely.
                        if (w_addr_bad) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_aerr  <= 1'b1;
                        end else begin
                            r_state <= S_ACCESS;
                            r_re    <= Read;
                            r_we    <= ~Read;
                        end
                    end
                end
                S_ACCESS: begin
                    r_re    <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= S_WAIT;
`ifdef MEM_IF_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                S_WAIT: begin
                    if (ram_ready) begin
                        if (r_is_read) begin
                            r_mdat <= ram_rdata;
                        end
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
`ifdef MEM_IF_TIMEOUT_EN
                    // Final unready WAIT cycle brings the count to TIMEOUT.
                    else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_tmo   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                        r_aerr  <= 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
                        r_tmo   <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Mdatain   = r_mdat;
    assign mem_done  = r_done;
    assign mem_busy  = (r_state != S_IDLE);
    assign addr_err  = r_aerr;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign ram_re    = r_re;
    assign ram_we    = r_we;
`ifdef MEM_IF_TIMEOUT_EN
    assign timeout   = r_tmo;
`else
    assign timeout   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_interface.sv
// ============================================================================
// Module   : tb_mem_interface
// Purpose  : Scoreboard bench for mem_interface (default and MEM_IF_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_interface;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 16;

    logic              clock = 1'b0;
    logic              clear;
    logic              Read;
    logic              Write;
    logic [31:0]       MARout;
    logic [31:0]       MDRout;
    logic [31:0]       Mdatain;
    logic              mem_done;
    logic              mem_busy;
    logic              addr_err;
    logic              timeout;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_re;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic              ram_ready;

    mem_interface #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) u_dut (
        .clock     (clock),
        .clear     (clear),
        .Read      (Read),
        .Write     (Write),
        .MARout    (MARout),
        .MDRout    (MDRout),
        .Mdatain   (Mdatain),
        .mem_done  (mem_done),
        .mem_busy  (mem_busy),
        .addr_err  (addr_err),
        .timeout   (timeout),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] mdat;
        logic        aerr;
        logic        tmo;
        int          lat;
        int          n_re;
        int          n_we;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mdat = 32'd0;

    // One access: expectation pushed at request, popped when mem_done appears.
    // ready_wait is the 1-based WAIT cycle in which ram_ready is raised.
    task automatic drive_access(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int ready_wait,
                                input int hold, input logic wr_in_wait,
                                input string name);
        exp_t        e;
        exp_t        got;
        int          re_cnt;
        int          we_cnt;
        int          done_cyc;
        int          lost;
        logic        aerr;
        logic        tmo;
        logic [31:0] hi;
        hi   = addr >> ADDR_W;
        aerr = (hi != 32'd0);
        tmo  = 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
        if (!aerr && ready_wait > TIMEOUT) tmo = 1'b1;
`endif
        if (rd && !aerr && !tmo) model_mdat = rdata;
        e.mdat = model_mdat;
        e.aerr = aerr;
        e.tmo  = tmo;
        e.lat  = aerr ? 1 : (tmo ? TIMEOUT + 2 : ready_wait + 2);
        e.n_re = (rd && !aerr) ? 1 : 0;
        e.n_we = (!rd && !aerr) ? 1 : 0;
        sb.push_back(e);

        @(negedge clock);
        Read = rd; Write = wr; MARout = addr; MDRout = wdata;
        ram_ready = 1'b0; ram_rdata = 32'h0BAD0BAD;
        re_cnt = 0; we_cnt = 0; done_cyc = 0;
        for (int c = 1; c <= 150 && done_cyc == 0; c++) begin
            @(negedge clock);
            if (ram_re) begin
                re_cnt++;
                checks++;
                if (ram_addr !== addr[ADDR_W-1:0]) begin
                    errors++;
                    $display("FAIL %s ram_addr got %h want %h", name, ram_addr, addr[ADDR_W-1:0]);
                end
            end
            if (ram_we) begin
                we_cnt++;
                checks++;
                if (ram_addr !== addr[ADDR_W-1:0] || ram_wdata !== wdata) begin
                    errors++;
                    $display("FAIL %s write addr/data got %h/%h want %h/%h", name,
                             ram_addr, ram_wdata, addr[ADDR_W-1:0], wdata);
                end
            end
            if (mem_done) begin
                done_cyc = c;
            end else begin
                // Ready during ACCESS (c==1) must be ignored.
                ram_ready = (c == 1) || (c - 1 == ready_wait);
                ram_rdata = (c - 1 == ready_wait) ? rdata : 32'h0BAD0BAD;
                if (wr_in_wait && c >= 2) Write = 1'b1;
            end
        end
        ram_ready = 1'b0;

        got = sb.pop_front();
        checks++;
        if (done_cyc != got.lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, done_cyc, got.lat);
        end
        checks++;
        if (Mdatain !== got.mdat) begin
            errors++;
            $display("FAIL %s Mdatain got %h want %h", name, Mdatain, got.mdat);
        end
        checks++;
        if (addr_err !== got.aerr || timeout !== got.tmo || mem_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s flags aerr/tmo/busy got %b%b%b want %b%b1", name,
                     addr_err, timeout, mem_busy, got.aerr, got.tmo);
        end
        checks++;
        if (re_cnt != got.n_re || we_cnt != got.n_we) begin
            errors++;
            $display("FAIL %s strobes re/we got %0d/%0d want %0d/%0d", name,
                     re_cnt, we_cnt, got.n_re, got.n_we);
        end

        lost = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            if (mem_done !== 1'b1) lost++;
        end
        if (hold > 0) begin
            checks++;
            if (lost != 0) begin
                errors++;
                $display("FAIL %s mem_done held got %0d drops want 0", name, lost);
            end
        end

        Read = 1'b0; Write = 1'b0;
        @(negedge clock);
        checks++;
        if (mem_done !== 1'b0 || mem_busy !== 1'b0 || addr_err !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s release done/busy/aerr/tmo got %b%b%b%b want 0000", name,
                     mem_done, mem_busy, addr_err, timeout);
        end
        if (done_cyc == 0) begin
            clear = 1'b0;
            model_mdat = 32'd0;
            @(negedge clock);
            clear = 1'b1;
        end
    endtask

    task automatic test_reset();
        clear = 1'b0; Read = 1'b0; Write = 1'b0; MARout = 32'd0; MDRout = 32'd0;
        ram_rdata = 32'd0; ram_ready = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (Mdatain !== 32'd0 || ram_addr !== '0 || ram_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset data got %h %h %h want 0", Mdatain, ram_addr, ram_wdata);
        end
        checks++;
        if ({ram_re, ram_we, mem_done, mem_busy, addr_err, timeout} !== 6'd0) begin
            errors++;
            $display("FAIL reset ctrl got %b want 000000",
                     {ram_re, ram_we, mem_done, mem_busy, addr_err, timeout});
        end
        clear = 1'b1;
    endtask

    task automatic test_read();
        drive_access(1'b1, 1'b0, 32'h0000_0012, 32'h0, 32'hDEAD_BEEF, 1, 0, 1'b0, "read");
    endtask

    task automatic test_write();
        drive_access(1'b0, 1'b1, 32'h0000_01FF, 32'hA5A5_A5A5, 32'h1111_2222, 5, 3, 1'b0, "write");
    endtask

    task automatic test_addr_err();
        drive_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h3333_4444, 1, 1, 1'b0, "addr_err");
    endtask

    task automatic test_priority();
        drive_access(1'b1, 1'b1, 32'h0000_0055, 32'h7777_7777, 32'hCAFE_F00D, 2, 0, 1'b0, "rd_wr_both");
        drive_access(1'b1, 1'b0, 32'h0000_00AA, 32'h8888_8888, 32'h0123_4567, 3, 1, 1'b1, "wr_in_wait");
    endtask

    task automatic test_timeout();
`ifdef MEM_IF_TIMEOUT_EN
        drive_access(1'b1, 1'b0, 32'h0000_0003, 32'h0, 32'h5555_AAAA, 1000, 0, 1'b0, "timeout");
        drive_access(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h6666_BBBB, TIMEOUT, 0, 1'b0, "ready_at_limit");
`else
        drive_access(1'b1, 1'b0, 32'h0000_0003, 32'h0, 32'h5555_AAAA, 101, 0, 1'b0, "long_wait");
`endif
    endtask

    task automatic test_clear_in_wait();
        @(negedge clock);
        Read = 1'b1; MARout = 32'h0000_0034; ram_ready = 1'b0;
        repeat (2) @(negedge clock);
        #2 clear = 1'b0;
        #1;
        checks++;
        if ({Mdatain, 23'd0, ram_addr} !== 64'd0 || ram_wdata !== 32'd0 ||
            {ram_re, ram_we, mem_done, mem_busy, addr_err, timeout} !== 6'd0) begin
            errors++;
            $display("FAIL async_clear got Mdatain=%h addr=%h ctrl=%b want zeros", Mdatain, ram_addr,
                     {ram_re, ram_we, mem_done, mem_busy, addr_err, timeout});
        end
        model_mdat = 32'd0;
        Read = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        drive_access(1'b1, 1'b0, 32'h0000_0101, 32'h0, 32'h8BAD_F00D, 1, 0, 1'b0, "after_clear");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic        rd;
            logic [31:0] a;
            rd = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 5) == 0) ? 32'h0001_0000 | $urandom_range(0, 511)
                                             : 32'($urandom_range(0, 511));
            drive_access(rd, ~rd, a, $urandom, $urandom, $urandom_range(1, 6),
                         $urandom_range(0, 2), 1'b0, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_addr_err();
        test_priority();
        test_timeout();
        test_clear_in_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
